// File: rtl/w_writeback.sv
// rtl/w_writeback.sv - W stage: M/W pipeline register, load extension, RF write-back select, retire counter
module w_writeback #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              M_valid,
  input  logic [DATA_W-1:0] M_PC,
  input  logic [4:0]        M_RWA,
  input  logic [1:0]        M_WDSel,
  input  logic [DATA_W-1:0] M_ALU,
  input  logic [DATA_W-1:0] M_MDR,
  input  logic [1:0]        M_addr_lo,
  input  logic [2:0]        M_ldtype,
  input  logic [DATA_W-1:0] M_HILO,
  output logic [4:0]        RWA,
  output logic [DATA_W-1:0] RWD,
  output logic [DATA_W-1:0] W_PC,
  output logic              W_valid,
  output logic [DATA_W-1:0] retired
);

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MEM  = 2'd1;
  localparam logic [1:0] WD_LINK = 2'd2;
  localparam logic [1:0] WD_HILO = 2'd3;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LB  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LH  = 3'd4;

  logic              r_valid;
  logic [DATA_W-1:0] r_pc;
  logic [4:0]        r_rwa;
  logic [1:0]        r_wdsel;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_mdr;
  logic [1:0]        r_addr_lo;
  logic [2:0]        r_ldtype;
  logic [DATA_W-1:0] r_hilo;
  logic [DATA_W-1:0] r_retired;

  logic              w_capture_valid;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_rwd;

  assign w_capture_valid = !flush && en && M_valid;

  // Flush loads an all-zero bubble so a flushed slot also drives RWD = 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rwa     <= '0;
      r_wdsel   <= WD_ALU;
      r_alu     <= '0;
      r_mdr     <= '0;
      r_addr_lo <= '0;
      r_ldtype  <= LD_LW;
      r_hilo    <= '0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rwa     <= '0;
      r_wdsel   <= WD_ALU;
      r_alu     <= '0;
      r_mdr     <= '0;
      r_addr_lo <= '0;
      r_ldtype  <= LD_LW;
      r_hilo    <= '0;
    end else if (en) begin
      r_valid   <= M_valid;
      r_pc      <= M_PC;
      r_rwa     <= M_RWA;
      r_wdsel   <= M_WDSel;
      r_alu     <= M_ALU;
      r_mdr     <= M_MDR;
      r_addr_lo <= M_addr_lo;
      r_ldtype  <= M_ldtype;
      r_hilo    <= M_HILO;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired <= '0;
    end else if (w_capture_valid) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_byte = r_mdr[7:0];
    case (r_addr_lo)
      2'd0: w_byte = r_mdr[7:0];
      2'd1: w_byte = r_mdr[15:8];
      2'd2: w_byte = r_mdr[23:16];
      2'd3: w_byte = r_mdr[31:24];
      default: w_byte = r_mdr[7:0];
    endcase
  end

  // Halfword loads are assumed aligned; the low offset bit is ignored.
  assign w_half = r_addr_lo[1] ? r_mdr[31:16] : r_mdr[15:0];

  always_comb begin
    w_load = r_mdr;
    case (r_ldtype)
      LD_LW:   w_load = r_mdr;
      LD_LBU:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
      LD_LB:   w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_LHU:  w_load = {{(DATA_W-16){1'b0}}, w_half};
      LD_LH:   w_load = {{(DATA_W-16){w_half[15]}}, w_half};
      default: w_load = r_mdr;
    endcase
  end

  always_comb begin
    w_rwd = r_alu;
    case (r_wdsel)
      WD_ALU:  w_rwd = r_alu;
      WD_MEM:  w_rwd = w_load;
      WD_LINK: w_rwd = r_pc + DATA_W'(8);
      WD_HILO: w_rwd = r_hilo;
      default: w_rwd = r_alu;
    endcase
  end

  assign RWA     = r_valid ? r_rwa : 5'd0;
  assign RWD     = w_rwd;
  assign W_PC    = r_pc;
  assign W_valid = r_valid;
  assign retired = r_retired;

endmodule

// File: tb/tb_w_writeback.sv
// tb/tb_w_writeback.sv - directed self-checking bench for w_writeback
module tb_w_writeback;

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic        M_valid;
  logic [31:0] M_PC;
  logic [4:0]  M_RWA;
  logic [1:0]  M_WDSel;
  logic [31:0] M_ALU;
  logic [31:0] M_MDR;
  logic [1:0]  M_addr_lo;
  logic [2:0]  M_ldtype;
  logic [31:0] M_HILO;
  logic [4:0]  RWA;
  logic [31:0] RWD;
  logic [31:0] W_PC;
  logic        W_valid;
  logic [31:0] retired;

  int n_checks;
  int n_errors;

  w_writeback #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .M_valid(M_valid),
    .M_PC(M_PC), .M_RWA(M_RWA), .M_WDSel(M_WDSel), .M_ALU(M_ALU),
    .M_MDR(M_MDR), .M_addr_lo(M_addr_lo), .M_ldtype(M_ldtype), .M_HILO(M_HILO),
    .RWA(RWA), .RWD(RWD), .W_PC(W_PC), .W_valid(W_valid), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_m(input logic v, input logic [4:0] rwa, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc);
    M_valid = v; M_RWA = rwa; M_WDSel = sel; M_ALU = alu; M_PC = pc;
  endtask

  task automatic load_case(input string tag, input logic [2:0] ldt,
                           input logic [1:0] lo, input logic [31:0] exp);
    set_m(1'b1, 5'd2, 2'd1, 32'h0, 32'h0000_1000);
    M_MDR = 32'h80FF7F01; M_addr_lo = lo; M_ldtype = ldt;
    step();
    check(tag, RWD, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0; en = 1'b0; flush = 1'b0;
    set_m(1'b0, 5'd0, 2'd0, 32'h0, 32'h0);
    M_MDR = 32'h0; M_addr_lo = 2'd0; M_ldtype = 3'd0; M_HILO = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    en = 1'b1;

    // Fill the stage, then pull reset mid-cycle and see everything clear at once.
    set_m(1'b1, 5'd3, 2'd0, 32'h0000_AAAA, 32'h0000_0040);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_rwa", {27'd0, RWA}, 32'd0);
    check("rst_rwd", RWD, 32'd0);
    check("rst_wpc", W_PC, 32'd0);
    check("rst_wvalid", {31'd0, W_valid}, 32'd0);
    check("rst_retired", retired, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    set_m(1'b1, 5'd5, 2'd0, 32'h1234_5678, 32'h0000_0100);
    step();
    check("alu_rwa", {27'd0, RWA}, 32'd5);
    check("alu_rwd", RWD, 32'h1234_5678);
    check("alu_wvalid", {31'd0, W_valid}, 32'd1);
    check("alu_retired", retired, 32'd1);

    load_case("ld_lb3",  3'd2, 2'd3, 32'hFFFF_FF80);
    load_case("ld_lbu3", 3'd1, 2'd3, 32'h0000_0080);
    load_case("ld_lh2",  3'd4, 2'd2, 32'hFFFF_80FF);
    load_case("ld_lhu0", 3'd3, 2'd0, 32'h0000_7F01);
    load_case("ld_lw",   3'd0, 2'd1, 32'h80FF_7F01);
    load_case("ld_t6",   3'd6, 2'd2, 32'h80FF_7F01);
    load_case("ld_lbu1", 3'd1, 2'd1, 32'h0000_007F);
    load_case("ld_lh1",  3'd4, 2'd1, 32'h0000_7F01);
    check("ld_retired", retired, 32'd9);

    set_m(1'b1, 5'd31, 2'd2, 32'h0, 32'h0000_3000);
    step();
    check("link_rwd", RWD, 32'h0000_3008);
    check("link_rwa", {27'd0, RWA}, 32'd31);
    check("link_wpc", W_PC, 32'h0000_3000);
    set_m(1'b1, 5'd31, 2'd2, 32'h0, 32'hFFFF_FFFC);
    step();
    check("link_wrap", RWD, 32'h0000_0004);
    set_m(1'b1, 5'd4, 2'd3, 32'h0, 32'h0000_3010);
    M_HILO = 32'hDEAD_BEEF;
    step();
    check("hilo_rwd", RWD, 32'hDEAD_BEEF);
    check("hilo_retired", retired, 32'd12);

    flush = 1'b1;
    set_m(1'b1, 5'd8, 2'd0, 32'h0000_0777, 32'h0000_4000);
    step();
    flush = 1'b0;
    check("flush_rwa", {27'd0, RWA}, 32'd0);
    check("flush_wvalid", {31'd0, W_valid}, 32'd0);
    check("flush_wpc", W_PC, 32'd0);
    check("flush_rwd", RWD, 32'd0);
    check("flush_retired", retired, 32'd12);

    set_m(1'b1, 5'd12, 2'd0, 32'h0000_55AA, 32'h0000_5000);
    step();
    check("pre_stall_retired", retired, 32'd13);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_m(1'b1, 5'(20 + i), 2'd3, 32'h1111_0000 + 32'(i), 32'h0000_6000);
      step();
      check("stall_rwa", {27'd0, RWA}, 32'd12);
      check("stall_rwd", RWD, 32'h0000_55AA);
      check("stall_retired", retired, 32'd13);
    end
    en = 1'b1;

    set_m(1'b0, 5'd9, 2'd0, 32'h0000_0999, 32'h0000_7000);
    step();
    check("bubble_rwa", {27'd0, RWA}, 32'd0);
    check("bubble_wvalid", {31'd0, W_valid}, 32'd0);
    check("bubble_retired", retired, 32'd13);

    // Backdoor preload of the retire counter while the stage is stalled.
    en = 1'b0;
    force dut.r_retired = 32'hFFFF_FFFF;
    #1 release dut.r_retired;
    #1 check("preload_retired", retired, 32'hFFFF_FFFF);
    en = 1'b1;
    set_m(1'b1, 5'd6, 2'd0, 32'h0000_0006, 32'h0000_8000);
    step();
    check("wrap_retired", retired, 32'd0);
    step();
    check("post_wrap_retired", retired, 32'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check("async_rst_retired", retired, 32'd0);
    check("async_rst_rwa", {27'd0, RWA}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
